// File: rtl/fs_pkg.sv
// Shared constants, circle offset tables and scan states for the FAST scan sequencer.
package fs_pkg;

  localparam int FS_NPTS   = 16;
  localparam int FS_RADIUS = 3;

  // Radius-3 Bresenham circle, p1..p16 clockwise from the top.
  localparam int FS_DX [FS_NPTS] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int FS_DY [FS_NPTS] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    FETCH = 3'd2,
    LAST  = 3'd3,
    EVAL  = 3'd4,
    DONE  = 3'd5
  } fs_state_t;

  function automatic int fs_offset(input int idx, input int img_w);
    return FS_DY[idx] * img_w + FS_DX[idx];
  endfunction

endpackage

// File: rtl/fs_circle_addr.sv
// Maps a centre address and fetch index k (0 = centre, 1..16 = p1..p16) to an image RAM address.
module fs_circle_addr
  import fs_pkg::*;
#(
  parameter int IMG_W  = 180,
  parameter int ADDR_W = 15
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [4:0]        k,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [ADDR_W-1:0] off_tab [FS_NPTS];
  logic [3:0]        idx;

  // Negative offsets wrap modulo 2^ADDR_W, so a plain add lands on the right pixel.
  for (genvar i = 0; i < FS_NPTS; i++) begin : g_off
    assign off_tab[i] = ADDR_W'(fs_offset(i, IMG_W));
  end

  assign idx = k[3:0] - 4'd1;

  // Centre read for k=0, otherwise centre plus the circle offset of p_k.
  always_comb begin
    if (k == 5'd0) begin
      rd_addr = addr;
    end else begin
      rd_addr = addr + off_tab[idx];
    end
  end

endmodule

// File: rtl/fs_scan_ctrl.sv
// Raster-scan sequencer: fetches centre plus 16 circle pixels per interior pixel,
// presents them to the score datapath and writes one score per pixel.
module fs_scan_ctrl
  import fs_pkg::*;
#(
  parameter int IMG_W   = 180,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 15,
  parameter int SCORE_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         threshold_in,
  output logic               busy,
  output logic               done,
  output logic               img_rd_en,
  output logic [ADDR_W-1:0]  img_rd_addr,
  input  logic [7:0]         img_rd_data,
  output logic               dp_valid,
  output logic [7:0]         dp_ref_pxl,
  output logic [127:0]       dp_sel_pxl,
  output logic [7:0]         dp_threshold,
  output logic [ADDR_W-1:0]  dp_ref_addr,
  input  logic               corner_in,
  input  logic [SCORE_W-1:0] score_in,
  output logic               score_wr_en,
  output logic [ADDR_W-1:0]  score_wr_addr,
  output logic [SCORE_W-1:0] score_wr_data,
  output logic [ADDR_W-1:0]  corner_cnt
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LO  = XW'(FS_RADIUS);
  localparam logic [XW-1:0] X_HI  = XW'(IMG_W - 1 - FS_RADIUS);
  localparam logic [XW-1:0] X_END = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LO  = YW'(FS_RADIUS);
  localparam logic [YW-1:0] Y_HI  = YW'(IMG_H - 1 - FS_RADIUS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  fs_state_t         state;
  logic [4:0]        k;
  logic [XW-1:0]     x, nx;
  logic [YW-1:0]     y, ny;
  logic [ADDR_W-1:0] addr, rd_addr, ref_addr, cnt;
  logic [7:0]        thr;
  logic [7:0]        bank [FS_NPTS+1];
  logic              next_interior, last_pixel;

  // Position of the pixel following the current one.
  always_comb begin
    if (x == X_END) begin
      nx = '0;
      ny = y + 1'b1;
    end else begin
      nx = x + 1'b1;
      ny = y;
    end
  end

  assign next_interior = (nx >= X_LO) && (nx <= X_HI) && (ny >= Y_LO) && (ny <= Y_HI);
  assign last_pixel    = (addr == LAST_ADDR);

  fs_circle_addr #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_circle (
    .addr    (addr),
    .k       (k),
    .rd_addr (rd_addr)
  );

  // Scan FSM, pixel counters and pixel bank. The interior/border decision is taken
  // while advancing, so an interior pixel goes straight from the advance into FETCH
  // and SCAN is only ever visited by border pixels (pixel 0 is always border).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= 5'd0;
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      thr      <= 8'd0;
      ref_addr <= '0;
      cnt      <= '0;
      for (int i = 0; i < FS_NPTS + 1; i++) begin
        bank[i] <= 8'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            thr   <= threshold_in;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            k     <= 5'd0;
            state <= SCAN;
          end
        end
        SCAN, EVAL: begin
          if ((state == EVAL) && corner_in) begin
            cnt <= cnt + 1'b1;
          end
          if (last_pixel) begin
            state <= DONE;
          end else begin
            x     <= nx;
            y     <= ny;
            addr  <= addr + 1'b1;
            k     <= 5'd0;
            state <= next_interior ? FETCH : SCAN;
          end
        end
        FETCH: begin
          // Read data lags the strobe by one cycle: store the previous read.
          if (k != 5'd0) begin
            bank[k - 5'd1] <= img_rd_data;
          end
          if (k == 5'd16) begin
            state <= LAST;
          end else begin
            k <= k + 1'b1;
          end
        end
        LAST: begin
          bank[16] <= img_rd_data;
          ref_addr <= addr;
          state    <= EVAL;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);
  assign img_rd_en     = (state == FETCH);
  assign img_rd_addr   = img_rd_en ? rd_addr : '0;
  assign score_wr_en   = (state == SCAN) || (state == EVAL);
  assign score_wr_addr = score_wr_en ? addr : '0;
  assign score_wr_data = ((state == EVAL) && corner_in) ? score_in : '0;
  assign dp_valid      = (state == EVAL);
  assign dp_ref_pxl    = bank[0];
  assign dp_threshold  = thr;
  assign dp_ref_addr   = ref_addr;
  assign corner_cnt    = cnt;

  for (genvar i = 0; i < FS_NPTS; i++) begin : g_sel
    assign dp_sel_pxl[8*i +: 8] = bank[i+1];
  end

endmodule

// File: tb/tb_fs_scan_ctrl.sv
// Scoreboard bench for fs_scan_ctrl on an 8x8 frame with a reference model of the scan.
module tb_fs_scan_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int AW = 8;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    threshold_in;
  logic          busy, done, img_rd_en, dp_valid, corner_in, score_wr_en;
  logic [AW-1:0] img_rd_addr, dp_ref_addr, score_wr_addr, corner_cnt;
  logic [7:0]    img_rd_data, dp_ref_pxl, dp_threshold;
  logic [127:0]  dp_sel_pxl;
  logic [SW-1:0] score_in, score_wr_data;

  always #5 clk = ~clk;

  fs_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold_in(threshold_in),
    .busy(busy), .done(done), .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
    .img_rd_data(img_rd_data), .dp_valid(dp_valid), .dp_ref_pxl(dp_ref_pxl),
    .dp_sel_pxl(dp_sel_pxl), .dp_threshold(dp_threshold), .dp_ref_addr(dp_ref_addr),
    .corner_in(corner_in), .score_in(score_in), .score_wr_en(score_wr_en),
    .score_wr_addr(score_wr_addr), .score_wr_data(score_wr_data), .corner_cnt(corner_cnt)
  );

  logic [7:0] mem [N];
  int gate_mode = 0;
  int errors = 0, checks = 0, done_seen = 0, frames_expected = 0, act_cnt = 0;
  int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  int           exp_wr_addr[$], exp_wr_data[$], exp_rd[$], exp_dp_addr[$];
  logic [7:0]   exp_dp_ref[$], exp_dp_th[$];
  logic [127:0] exp_dp_sel[$];

  always @(posedge clk) begin
    if (img_rd_en) img_rd_data <= mem[img_rd_addr[5:0]];
  end

  // Datapath stub: order-sensitive weighted sum so a misplaced pixel changes the score.
  function automatic logic [12:0] stub_fn(input logic [7:0] r, input logic [127:0] s, input logic [7:0] t);
    int acc;
    acc = int'(r) + 3 * int'(t);
    for (int i = 0; i < 16; i++) acc += (i + 1) * int'(s[8*i +: 8]);
    return {((acc % 5) != 0), acc[11:0]};
  endfunction

  always_comb begin
    if (gate_mode != 0) begin
      corner_in = (dp_ref_addr == 8'd36);
      score_in  = 12'h2A0;
    end else begin
      {corner_in, score_in} = stub_fn(dp_ref_pxl, dp_sel_pxl, dp_threshold);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, a write or a bank.
  always @(negedge clk) begin
    if (!rst) begin
      if (score_wr_en) begin
        act_cnt++;
        if (exp_wr_addr.size() == 0) fail("unexpected_score_write");
        else begin
          check("wr_addr", score_wr_addr, exp_wr_addr.pop_front());
          check("wr_data", score_wr_data, exp_wr_data.pop_front());
        end
      end
      if (img_rd_en) begin
        act_cnt++;
        check("rd_in_range", img_rd_addr < N, 1);
        if (exp_rd.size() == 0) fail("unexpected_read");
        else check("rd_addr", img_rd_addr, exp_rd.pop_front());
      end
      if (dp_valid) begin
        if (exp_dp_addr.size() == 0) fail("unexpected_dp_valid");
        else begin
          check("dp_ref_addr", dp_ref_addr, exp_dp_addr.pop_front());
          check("dp_ref_pxl", dp_ref_pxl, exp_dp_ref.pop_front());
          check("dp_sel_pxl", dp_sel_pxl, exp_dp_sel.pop_front());
          check("dp_threshold", dp_threshold, exp_dp_th.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic clear_queues();
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd.delete();
    exp_dp_addr.delete(); exp_dp_ref.delete(); exp_dp_th.delete(); exp_dp_sel.delete();
  endtask

  // Reference model: walks the frame in (x,y) and derives every expected transaction.
  task automatic build_model(input logic [7:0] th, output int ncorner);
    ncorner = 0;
    for (int a = 0; a < N; a++) begin
      int x, y, ca;
      logic [127:0] sel;
      logic [12:0] r;
      x = a % W;
      y = a / W;
      sel = '0;
      exp_wr_addr.push_back(a);
      if (x >= 3 && x <= W - 4 && y >= 3 && y <= H - 4) begin
        exp_rd.push_back(a);
        for (int i = 0; i < 16; i++) begin
          ca = (y + DY[i]) * W + (x + DX[i]);
          exp_rd.push_back(ca);
          sel[8*i +: 8] = mem[ca];
        end
        exp_dp_addr.push_back(a); exp_dp_ref.push_back(mem[a]);
        exp_dp_sel.push_back(sel); exp_dp_th.push_back(th);
        if (gate_mode != 0) r = {(a == 36), 12'h2A0};
        else r = stub_fn(mem[a], sel, th);
        exp_wr_data.push_back(r[12] ? int'(r[11:0]) : 0);
        if (r[12]) ncorner++;
      end else begin
        exp_wr_data.push_back(0);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] th, input bit poke);
    int ncorner, cyc;
    build_model(th, ncorner);
    @(negedge clk);
    start = 1'b1; threshold_in = th;
    @(posedge clk);
    #1 start = 1'b0; threshold_in = 8'($urandom);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (cyc >= 3000) begin fail("frame_timeout"); break; end
      if (poke && cyc == 50) begin start = 1'b1; threshold_in = 8'd99; end
      else start = 1'b0;
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    #1;
    frames_expected++;
    check("frame_cycles", cyc, 136);
    check("corner_cnt", corner_cnt, ncorner);
    check("frame_dp_threshold", dp_threshold, th);
    check("wr_queue_drained", exp_wr_addr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("dp_queue_drained", exp_dp_addr.size(), 0);
    check("done_pulses", done_seen, frames_expected);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_img_rd"}, {img_rd_en, img_rd_addr}, 0);
    check({p, "_score_wr"}, {score_wr_en, score_wr_addr, score_wr_data}, 0);
    check({p, "_dp_valid"}, dp_valid, 0);
    check({p, "_dp_ref"}, {dp_ref_pxl, dp_ref_addr, dp_threshold}, 0);
    check({p, "_dp_sel"}, dp_sel_pxl, 0);
    check({p, "_corner_cnt"}, corner_cnt, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dummy;
    rst = 1'b1; start = 1'b0; threshold_in = 8'd0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Address-valued RAM, busy-time start with a different threshold.
    run_frame(8'd20, 1'b1);
    // Back-to-back identical frame.
    run_frame(8'd20, 1'b0);

    gate_mode = 1;
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    run_frame(8'($urandom), 1'b0);
    gate_mode = 0;

    repeat (2) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      run_frame(8'($urandom), 1'b0);
    end

    // Reset during the centre fetch of pixel 27.
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    build_model(8'd20, dummy);
    @(negedge clk);
    start = 1'b1; threshold_in = 8'd20;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (img_rd_en && img_rd_addr == 8'd27) break;
      if (cyc >= 500) begin fail("wait_pixel27_timeout"); break; end
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 check_all_zero("midrst");
    clear_queues();
    @(negedge clk) rst = 1'b0;
    act_cnt = 0;
    repeat (40) @(negedge clk);
    #1;
    check("midrst_activity", act_cnt, 0);
    check("midrst_no_done", done_seen, frames_expected);
    run_frame(8'd20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
